// File: rtl/fighter_motion_p1.sv
// Player-1 position integrator: per-frame horizontal walk/knockback with wall and
// opponent-separation clamps, plus a jump/gravity state machine for vertical motion.
module fighter_motion_p1 #(
    parameter int X_START    = 100,
    parameter int Y_GROUND   = 400,
    parameter int X_MIN      = 7,
    parameter int X_MAX      = 632,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_V0    = 12,
    parameter int GRAVITY    = 1,
    parameter int MIN_SEP    = 40
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               Left,
    input  logic               Right,
    input  logic               Jump,
    input  logic signed [31:0] Ball_X_Motion,
    input  logic signed [31:0] Opp_Xpos,
    output logic signed [31:0] Xpos,
    output logic signed [31:0] Ypos,
    output logic               Airborne
);

    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_RISE   = 2'd1;
    localparam logic [1:0] ST_FALL   = 2'd2;

    logic signed [31:0] x_q, x_d;
    logic signed [31:0] y_q, y_d;
    logic signed [31:0] vy_q, vy_d;
    logic [1:0]         state_q, state_d;
    logic               air_q, air_d;
    logic               frame_d_q;
    logic               armed_q, armed_d;
    logic               tick;

    logic signed [31:0] vx;
    logic signed [31:0] nx;
    logic signed [31:0] sep_lim;
    logic signed [31:0] vy_next;

    assign tick = frame_clk & ~frame_d_q;

    // Horizontal: knockback overrides the walk keys; separation only limits rightward motion.
    always_comb begin
        vx      = 32'sd0;
        nx      = 32'sd0;
        sep_lim = Opp_Xpos - MIN_SEP;
        if (Ball_X_Motion != 32'sd0) begin
            vx = Ball_X_Motion;
        end else if (Right && !Left) begin
            vx = WALK_SPEED;
        end else if (Left && !Right) begin
            vx = -WALK_SPEED;
        end
        nx = x_q + vx;
        if (vx > 32'sd0 && nx > sep_lim) begin
            nx = (x_q > sep_lim) ? x_q : sep_lim;
        end
        if (nx < X_MIN) begin
            nx = X_MIN;
        end else if (nx > X_MAX) begin
            nx = X_MAX;
        end
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        state_d = state_q;
        armed_d = armed_q;
        vy_next = 32'sd0;
        if (tick) begin
            x_d = nx;
            if (!Jump) begin
                armed_d = 1'b1;
            end
            case (state_q)
                ST_GROUND: begin
                    if (Jump && armed_q) begin
                        state_d = ST_RISE;
                        vy_d    = JUMP_V0;
                        armed_d = 1'b0;
                    end
                end
                ST_RISE: begin
                    y_d     = y_q - vy_q;
                    vy_next = vy_q - GRAVITY;
                    if (vy_next <= 32'sd0) begin
                        state_d = ST_FALL;
                        vy_d    = 32'sd0;
                    end else begin
                        vy_d = vy_next;
                    end
                end
                ST_FALL: begin
                    // Snap to the ground rather than overshooting it.
                    if (y_q + vy_q >= Y_GROUND) begin
                        y_d     = Y_GROUND;
                        vy_d    = 32'sd0;
                        state_d = ST_GROUND;
                    end else begin
                        y_d  = y_q + vy_q;
                        vy_d = vy_q + GRAVITY;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                    y_d     = Y_GROUND;
                    vy_d    = 32'sd0;
                end
            endcase
        end
        air_d = (state_d != ST_GROUND);
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            x_q       <= X_START;
            y_q       <= Y_GROUND;
            vy_q      <= 32'sd0;
            state_q   <= ST_GROUND;
            air_q     <= 1'b0;
            frame_d_q <= 1'b0;
            armed_q   <= 1'b1;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vy_q      <= vy_d;
            state_q   <= state_d;
            air_q     <= air_d;
            frame_d_q <= frame_clk;
            armed_q   <= armed_d;
        end
    end

    assign Xpos     = x_q;
    assign Ypos     = y_q;
    assign Airborne = air_q;

endmodule

// File: tb/tb_fighter_motion_p1.sv
// Directed bench for fighter_motion_p1: table of per-frame vectors plus hand-written
// sequences for held frame strobe, jump arcs, re-arm and reset mid-jump.
module tb_fighter_motion_p1;

    logic               clk = 1'b0;
    logic               Reset;
    logic               frame_clk;
    logic               Left;
    logic               Right;
    logic               Jump;
    logic signed [31:0] Ball_X_Motion;
    logic signed [31:0] Opp_Xpos;
    logic signed [31:0] Xpos;
    logic signed [31:0] Ypos;
    logic               Airborne;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fighter_motion_p1 dut (
        .clk          (clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Left         (Left),
        .Right        (Right),
        .Jump         (Jump),
        .Ball_X_Motion(Ball_X_Motion),
        .Opp_Xpos     (Opp_Xpos),
        .Xpos         (Xpos),
        .Ypos         (Ypos),
        .Airborne     (Airborne)
    );

    typedef struct {
        logic        left;
        logic        right;
        logic        jump;
        int          ball;
        int          opp;
        int          exp_x;
        int          exp_y;
        logic        exp_air;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int ex, input int ey, input logic eair);
        n_vec++;
        if (Xpos !== ex || Ypos !== ey || Airborne !== eair) begin
            n_miss++;
            $display("FAIL %s: got X=%0d Y=%0d Air=%b, want X=%0d Y=%0d Air=%b",
                     name, Xpos, Ypos, Airborne, ex, ey, eair);
        end
    endtask

    // One frame: drive inputs at negedge, strobe frame_clk high for 2 clks then low 2 clks.
    task automatic frame_tick(input logic l, input logic r, input logic j, input int ball,
                              input int opp);
        @(negedge clk);
        Left = l; Right = r; Jump = j; Ball_X_Motion = ball; Opp_Xpos = opp;
        frame_clk = 1'b1;
        repeat (2) @(negedge clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n, input logic j);
        for (int i = 0; i < n; i++) frame_tick(1'b0, 1'b0, j, 0, 5000);
    endtask

    initial begin
        //          L     R     J     ball   opp   X    Y    Air
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 0,     1000, 102, 400, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 0,     1000, 104, 400, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 0,     1000, 106, 400, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 0,     1000, 108, 400, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 0,     1000, 110, 400, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 0,     1000, 110, 400, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 0,     1000, 110, 400, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 0,     1000, 110, 400, 1'b0};
        // Second part (after held-frame sequence leaves X=112)
        vecs[8]  = '{1'b0, 1'b0, 1'b0, -102,  1000, 10,  400, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, -9,    1000, 7,   400, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 0,     1000, 7,   400, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 149,   1000, 156, 400, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 0,     200,  158, 400, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 0,     200,  160, 400, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 0,     200,  160, 400, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 0,     200,  158, 400, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 0,     150,  158, 400, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1000,  5000, 632, 400, 1'b0};

        Reset = 1'b0; frame_clk = 1'b0; Left = 1'b0; Right = 1'b0; Jump = 1'b0;
        Ball_X_Motion = 0; Opp_Xpos = 1000;
        repeat (3) @(posedge clk);
        #1 check("reset", 100, 400, 1'b0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", 100, 400, 1'b0);

        for (int i = 0; i < 8; i++) begin
            frame_tick(vecs[i].left, vecs[i].right, vecs[i].jump, vecs[i].ball, vecs[i].opp);
            check($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_air);
        end

        // frame_clk held high for 10 clks must give a single update.
        @(negedge clk);
        Left = 1'b0; Right = 1'b1; frame_clk = 1'b1;
        repeat (10) @(negedge clk);
        check("held_frame_high", 112, 400, 1'b0);
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("held_frame_low", 112, 400, 1'b0);

        for (int i = 8; i < 18; i++) begin
            frame_tick(vecs[i].left, vecs[i].right, vecs[i].jump, vecs[i].ball, vecs[i].opp);
            check($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_air);
        end

        // Knockback and jump on the same tick; Jump then held through the arc.
        frame_tick(1'b0, 1'b0, 1'b1, -32, 5000);
        check("jump_knock", 600, 400, 1'b1);
        ticks(12, 1'b1);
        check("jump_peak", 600, 322, 1'b1);
        ticks(12, 1'b1);
        check("jump_before_land", 600, 388, 1'b1);
        ticks(1, 1'b1);
        check("jump_landed", 600, 400, 1'b0);
        ticks(1, 1'b1);
        check("held_no_rejump", 600, 400, 1'b0);
        ticks(1, 1'b0);
        check("released", 600, 400, 1'b0);
        ticks(1, 1'b1);
        check("rejump", 600, 400, 1'b1);
        ticks(5, 1'b1);
        check("rise_350", 600, 350, 1'b1);

        // Reset mid-jump, with a frame strobe that must be ignored.
        @(negedge clk);
        Reset = 1'b0; frame_clk = 1'b1;
        @(posedge clk);
        #1 check("reset_mid_jump", 100, 400, 1'b0);
        @(negedge clk);
        frame_clk = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        repeat (2) @(negedge clk);
        check("after_reset_release", 100, 400, 1'b0);

        ticks(1, 1'b1);
        check("jump2_start", 100, 400, 1'b1);
        ticks(24, 1'b1);
        check("jump2_tick24", 100, 388, 1'b1);
        ticks(1, 1'b0);
        check("jump2_landed", 100, 400, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
